// File: rtl/gnn_pkg.sv
// gnn_pkg: shared defaults, the adjacency constant and the types used by the
// GNN node scheduler and its result buffer.
package gnn_pkg;

    localparam int NUM_NODES_DEF = 4;
    localparam int OUT_W_DEF     = 21;
    localparam int TIMEOUT_DEF   = 64;

    // Diamond graph neighbour masks, self included.
    // Row n lives at [n*4 +: 4]: n0=0111, n1=1011, n2=1101, n3=1110.
    localparam logic [15:0] ADJ_DIAMOND = 16'hEDB7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    typedef logic [$clog2(NUM_NODES_DEF)-1:0] node_idx_t;

endpackage

// File: rtl/gnn_result_buf.sv
// gnn_result_buf: per-node result slots for both engine outputs.
// One write port per output half (shared slot index), a clear-all input and
// packed read ports; slot n occupies [n*OUT_W +: OUT_W].
module gnn_result_buf
    import gnn_pkg::*;
#(
    parameter int NUM_NODES = NUM_NODES_DEF,
    parameter int OUT_W     = OUT_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         we0,
    input  logic                         we1,
    input  logic [$clog2(NUM_NODES)-1:0] idx,
    input  logic [OUT_W-1:0]             din0,
    input  logic [OUT_W-1:0]             din1,
    output logic [NUM_NODES*OUT_W-1:0]   res_out0,
    output logic [NUM_NODES*OUT_W-1:0]   res_out1
);

    logic [NUM_NODES*OUT_W-1:0] slot0_r;
    logic [NUM_NODES*OUT_W-1:0] slot1_r;

    // Slot storage: reset or clear wipes every slot, otherwise each half writes at idx.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            slot0_r <= '0;
            slot1_r <= '0;
        end else begin
            if (we0) begin
                slot0_r[int'(idx)*OUT_W +: OUT_W] <= din0;
            end
            if (we1) begin
                slot1_r[int'(idx)*OUT_W +: OUT_W] <= din1;
            end
        end
    end

    assign res_out0 = slot0_r;
    assign res_out1 = slot1_r;

endmodule

// File: rtl/gnn_node_scheduler.sv
// gnn_node_scheduler: time-multiplexes one GNN layer engine over all graph nodes.
// For each node it presents node_sel/agg_mask, pulses eng_start, waits for both
// engine outputs (any order) and stores them in gnn_result_buf; the full result
// vector is then offered on res_valid/res_ready.
// Optional feature macro: GNN_SCHED_WATCHDOG_EN (WAIT-state watchdog, err flag).
module gnn_node_scheduler
    import gnn_pkg::*;
#(
    parameter int                             NUM_NODES = NUM_NODES_DEF,
    parameter int                             OUT_W     = OUT_W_DEF,
    parameter logic [NUM_NODES*NUM_NODES-1:0] ADJ       = ADJ_DIAMOND
`ifdef GNN_SCHED_WATCHDOG_EN
    ,
    parameter int                             TIMEOUT   = TIMEOUT_DEF
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         job_valid,
    output logic                         job_ready,
    output logic [$clog2(NUM_NODES)-1:0] node_sel,
    output logic [NUM_NODES-1:0]         agg_mask,
    output logic                         eng_start,
    input  logic [OUT_W-1:0]             eng_out0,
    input  logic [OUT_W-1:0]             eng_out1,
    input  logic                         eng_out0_ready,
    input  logic                         eng_out1_ready,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [NUM_NODES*OUT_W-1:0]   res_out0,
    output logic [NUM_NODES*OUT_W-1:0]   res_out1,
    output logic                         busy,
    output logic                         err
);

    localparam int IDX_W = $clog2(NUM_NODES);

    sched_state_t     state_r;
    logic [IDX_W-1:0] node_sel_r;
    logic             eng_start_r;
    logic             job_ready_r;
    logic             busy_r;
    logic             res_valid_r;
    logic             got0_r;
    logic             got1_r;

    logic             accept_s;
    logic             in_wait_s;
    logic             both_s;
    logic             timeout_s;
    logic             advance_s;
    logic             last_s;
    logic             we0_s;
    logic             we1_s;
    logic [OUT_W-1:0] din0_s;
    logic [OUT_W-1:0] din1_s;

`ifdef GNN_SCHED_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_r;
    logic             err_r;
`endif

    assign accept_s = job_valid && job_ready_r && (state_r == IDLE);

    // WAIT-cycle decode: completion, watchdog expiry and which result halves to write.
    always_comb begin
        in_wait_s = (state_r == WAIT);
        both_s    = (got0_r || eng_out0_ready) && (got1_r || eng_out1_ready);
`ifdef GNN_SCHED_WATCHDOG_EN
        timeout_s = in_wait_s && !both_s && (wait_cnt_r == CNT_W'(TIMEOUT - 1));
`else
        timeout_s = 1'b0;
`endif
        advance_s = in_wait_s && (both_s || timeout_s);
        last_s    = (node_sel_r == IDX_W'(NUM_NODES - 1));

        // A late output is replaced by zero when the watchdog gives up on it.
        if (in_wait_s && eng_out0_ready) begin
            we0_s  = 1'b1;
            din0_s = eng_out0;
        end else if (timeout_s && !got0_r) begin
            we0_s  = 1'b1;
            din0_s = '0;
        end else begin
            we0_s  = 1'b0;
            din0_s = '0;
        end

        if (in_wait_s && eng_out1_ready) begin
            we1_s  = 1'b1;
            din1_s = eng_out1;
        end else if (timeout_s && !got1_r) begin
            we1_s  = 1'b1;
            din1_s = '0;
        end else begin
            we1_s  = 1'b0;
            din1_s = '0;
        end
    end

    // Sequencing FSM: job accept, per-node issue/wait handshake, result hand-off.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            node_sel_r  <= '0;
            eng_start_r <= 1'b0;
            job_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
            got0_r      <= 1'b0;
            got1_r      <= 1'b0;
`ifdef GNN_SCHED_WATCHDOG_EN
            wait_cnt_r  <= '0;
            err_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r     <= ISSUE;
                        node_sel_r  <= '0;
                        eng_start_r <= 1'b1;
                        job_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
`ifdef GNN_SCHED_WATCHDOG_EN
                        err_r       <= 1'b0;
`endif
                    end
                end
                ISSUE: begin
                    state_r     <= WAIT;
                    eng_start_r <= 1'b0;
                    got0_r      <= 1'b0;
                    got1_r      <= 1'b0;
`ifdef GNN_SCHED_WATCHDOG_EN
                    wait_cnt_r  <= '0;
`endif
                end
                WAIT: begin
                    got0_r <= got0_r || eng_out0_ready;
                    got1_r <= got1_r || eng_out1_ready;
`ifdef GNN_SCHED_WATCHDOG_EN
                    wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    if (timeout_s) begin
                        err_r <= 1'b1;
                    end
`endif
                    if (advance_s) begin
                        if (last_s) begin
                            state_r     <= DONE;
                            res_valid_r <= 1'b1;
                        end else begin
                            state_r     <= ISSUE;
                            node_sel_r  <= node_sel_r + IDX_W'(1);
                            eng_start_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_r     <= IDLE;
                        res_valid_r <= 1'b0;
                        job_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    node_sel_r  <= '0;
                    eng_start_r <= 1'b0;
                    job_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Neighbour mask of the node currently presented to the engine.
    always_comb begin
        agg_mask = ADJ[int'(node_sel_r)*NUM_NODES +: NUM_NODES];
    end

    gnn_result_buf #(
        .NUM_NODES (NUM_NODES),
        .OUT_W     (OUT_W)
    ) u_result_buf (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept_s),
        .we0      (we0_s),
        .we1      (we1_s),
        .idx      (node_sel_r),
        .din0     (din0_s),
        .din1     (din1_s),
        .res_out0 (res_out0),
        .res_out1 (res_out1)
    );

    assign job_ready = job_ready_r;
    assign node_sel  = node_sel_r;
    assign eng_start = eng_start_r;
    assign res_valid = res_valid_r;
    assign busy      = busy_r;
`ifdef GNN_SCHED_WATCHDOG_EN
    assign err       = err_r;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_gnn_node_scheduler.sv
// tb_gnn_node_scheduler: randomized bench with a behavioural engine model.
// Expected results, masks and latencies come from the graph rules and per-node
// engine latencies; with GNN_SCHED_WATCHDOG_EN the DUT is built with TIMEOUT=8.
module tb_gnn_node_scheduler;
    import gnn_pkg::*;

    localparam int NN = 4;
    localparam int OW = 21;
    localparam int IW = $clog2(NN);
`ifdef GNN_SCHED_WATCHDOG_EN
    localparam int WD = 8;
`else
    localparam int WD = 1000000;
`endif

    logic               clk;
    logic               rst;
    logic               job_valid;
    logic               job_ready;
    logic [IW-1:0]      node_sel;
    logic [NN-1:0]      agg_mask;
    logic               eng_start;
    logic [OW-1:0]      eng_out0;
    logic [OW-1:0]      eng_out1;
    logic               eng_out0_ready;
    logic               eng_out1_ready;
    logic               res_valid;
    logic               res_ready;
    logic [NN*OW-1:0]   res_out0;
    logic [NN*OW-1:0]   res_out1;
    logic               busy;
    logic               err;

    int n_checks = 0;
    int n_pass   = 0;
    int unsigned cyc = 0;

    // Engine model configuration: per-node output latencies and data.
    int          lat0 [NN];
    int          lat1 [NN];
    logic [OW-1:0] d0 [NN];
    logic [OW-1:0] d1 [NN];
    bit          spur0 = 1'b0;
    bit          spur1 = 1'b0;
    bit          spur_issue = 1'b0;
    logic [NN*OW-1:0] last_e0;
    logic [NN*OW-1:0] last_e1;

    bit          eng_act;
    int          ecnt;
    int          ecur;
    bit          m0, m1, s_iss;
    logic [OW-1:0] nd0, nd1;

`ifdef GNN_SCHED_WATCHDOG_EN
    gnn_node_scheduler #(.TIMEOUT(8)) dut (
`else
    gnn_node_scheduler dut (
`endif
        .clk            (clk),
        .rst            (rst),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .node_sel       (node_sel),
        .agg_mask       (agg_mask),
        .eng_start      (eng_start),
        .eng_out0       (eng_out0),
        .eng_out1       (eng_out1),
        .eng_out0_ready (eng_out0_ready),
        .eng_out1_ready (eng_out1_ready),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_out0       (res_out0),
        .res_out1       (res_out1),
        .busy           (busy),
        .err            (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    // Each node neighbours every node except the one diagonally opposite it.
    function automatic logic [NN-1:0] exp_mask(input int n);
        logic [NN-1:0] m;
        m = '1;
        m[NN-1-n] = 1'b0;
        return m;
    endfunction

    // Engine model: responds L cycles after each start pulse, plus forced stale flags.
    initial begin
        eng_out0_ready = 1'b0;
        eng_out1_ready = 1'b0;
        eng_out0 = '0;
        eng_out1 = '0;
        eng_act = 1'b0;
        ecnt = 0;
        ecur = 0;
        forever begin
            @(negedge clk);
            m0 = 1'b0;
            m1 = 1'b0;
            if (eng_act) begin
                ecnt++;
                m0 = (ecnt == lat0[ecur]);
                m1 = (ecnt == lat1[ecur]);
            end
            nd0 = m0 ? d0[ecur] : OW'($urandom);
            nd1 = m1 ? d1[ecur] : OW'($urandom);
            s_iss = 1'b0;
            if (eng_start === 1'b1) begin
                eng_act = 1'b1;
                ecnt = 0;
                ecur = int'(node_sel);
                chk("agg_mask", agg_mask, exp_mask(ecur));
                s_iss = spur_issue;
            end
            eng_out0_ready = m0 | spur0 | s_iss;
            eng_out1_ready = m1 | spur1;
            eng_out0 = nd0;
            eng_out1 = nd1;
        end
    end

    // One full job: predicted latency, results and err versus the DUT, optional DONE hold.
    task automatic run_job(input string name, input int hold);
        int exp_lat;
        int m;
        bit exp_err;
        int unsigned acc;
        logic [NN*OW-1:0] e0;
        logic [NN*OW-1:0] e1;
        exp_lat = 1;
        exp_err = 1'b0;
        e0 = '0;
        e1 = '0;
        for (int n = 0; n < NN; n++) begin
            m = (lat0[n] > lat1[n]) ? lat0[n] : lat1[n];
            if (m > WD) begin
                m = WD;
                exp_err = 1'b1;
            end
            exp_lat += m + 1;
            e0[n*OW +: OW] = (lat0[n] <= WD) ? d0[n] : '0;
            e1[n*OW +: OW] = (lat1[n] <= WD) ? d1[n] : '0;
        end
        last_e0 = e0;
        last_e1 = e1;
        @(negedge clk);
        chk({name, ":job_ready"}, job_ready, 1'b1);
        job_valid = 1'b1;
        acc = cyc;
        @(negedge clk);
        job_valid = 1'b0;
        chk({name, ":busy"}, busy, 1'b1);
        chk({name, ":err_cleared"}, err, 1'b0);
        while (res_valid !== 1'b1 && (cyc - acc) < 400) @(negedge clk);
        chk({name, ":latency"}, cyc - acc, exp_lat);
        chk({name, ":res_out0"}, res_out0, e0);
        chk({name, ":res_out1"}, res_out1, e1);
        chk({name, ":err"}, err, exp_err);
        for (int h = 0; h < hold; h++) begin
            job_valid = 1'b1;
            spur0 = 1'b1;
            spur1 = 1'b1;
            @(negedge clk);
            chk({name, ":hold_valid"}, res_valid, 1'b1);
            chk({name, ":hold_out0"}, res_out0, e0);
            chk({name, ":hold_out1"}, res_out1, e1);
            chk({name, ":hold_job_ready"}, job_ready, 1'b0);
        end
        spur0 = 1'b0;
        spur1 = 1'b0;
        res_ready = 1'b1;
        job_valid = (hold > 0);
        @(negedge clk);
        res_ready = 1'b0;
        job_valid = 1'b0;
        chk({name, ":drain_valid"}, res_valid, 1'b0);
        chk({name, ":drain_job_ready"}, job_ready, 1'b1);
        chk({name, ":drain_busy"}, busy, 1'b0);
    endtask

    task automatic set_uniform(input int l0, input int l1);
        for (int n = 0; n < NN; n++) begin
            lat0[n] = l0;
            lat1[n] = l1;
            d0[n] = OW'($urandom);
            d1[n] = OW'($urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        int tmo;
        rst = 1'b1;
        job_valid = 1'b0;
        res_ready = 1'b0;
        set_uniform(3, 3);
        repeat (3) @(negedge clk);
        chk("rst:job_ready", job_ready, 1'b1);
        chk("rst:res_valid", res_valid, 1'b0);
        chk("rst:eng_start", eng_start, 1'b0);
        chk("rst:busy", busy, 1'b0);
        chk("rst:err", err, 1'b0);
        chk("rst:node_sel", node_sel, '0);
        chk("rst:res_out0", res_out0, '0);
        rst = 1'b0;

        // Fixed L=3, out0=n+1, out1=-(n+1).
        for (int n = 0; n < NN; n++) begin
            lat0[n] = 3;
            lat1[n] = 3;
            d0[n] = OW'(n + 1);
            d1[n] = -OW'(n + 1);
        end
        run_job("basic", 0);

        // out1 two cycles ahead of out0 on every node.
        set_uniform(4, 2);
        run_job("out1_first", 0);

        // Long DONE hold with job_valid and stale engine flags present.
        set_uniform(2, 5);
        run_job("hold", 10);

        // Stale out0 flag during ISSUE, then stale flags in IDLE.
        set_uniform(3, 1);
        spur_issue = 1'b1;
        run_job("spur_issue", 0);
        spur_issue = 1'b0;
        spur0 = 1'b1;
        spur1 = 1'b1;
        repeat (3) @(negedge clk);
        spur0 = 1'b0;
        spur1 = 1'b0;
        chk("idle_spur:res_out0", res_out0, last_e0);
        chk("idle_spur:res_out1", res_out1, last_e1);
        chk("idle_spur:busy", busy, 1'b0);

        // Randomized latencies, data and hold times.
        for (int j = 0; j < 6; j++) begin
            for (int n = 0; n < NN; n++) begin
                lat0[n] = $urandom_range(1, 6);
                lat1[n] = $urandom_range(1, 6);
                d0[n] = OW'($urandom);
                d1[n] = OW'($urandom);
            end
            run_job("rand", $urandom_range(0, 3));
        end

`ifdef GNN_SCHED_WATCHDOG_EN
        // out1 of node 1 never arrives: slot zeroed, err raised, sequencing continues.
        set_uniform(2, 2);
        lat1[1] = 1000;
        run_job("watchdog", 0);
        set_uniform(2, 3);
        run_job("after_watchdog", 0);
`endif

        // Reset while waiting on node 2.
        for (int n = 0; n < NN; n++) begin
            lat0[n] = 3;
            lat1[n] = 3;
            d0[n] = OW'(n + 5);
            d1[n] = OW'(n + 9);
        end
        @(negedge clk);
        job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        tmo = 0;
        while (!(node_sel == IW'(2) && busy === 1'b1 && eng_start === 1'b0) && tmo < 100) begin
            @(negedge clk);
            tmo++;
        end
        chk("midrst:reach_node2", (tmo < 100), 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst:job_ready", job_ready, 1'b1);
        chk("midrst:busy", busy, 1'b0);
        chk("midrst:eng_start", eng_start, 1'b0);
        chk("midrst:node_sel", node_sel, '0);
        chk("midrst:res_out0", res_out0, '0);
        chk("midrst:res_out1", res_out1, '0);
        chk("midrst:res_valid", res_valid, 1'b0);

        set_uniform(1, 2);
        run_job("post_rst", 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
